// File: rtl/apb_spi_initiator.sv
// apb_spi_initiator: hardware APB initiator that sequences one SPI byte transfer on the
// APB-to-SPI master bridge. Each accepted request produces three APB writes (CONFIG, TX, CMD),
// a fixed wait, STATUS polling until the busy bit clears (or a poll budget runs out), and an
// optional RX read. A single-cycle response pulse reports the RX byte and a timeout flag.
//
// Ports:
//   i_PCLK, i_PRESET          clock, asynchronous active-high reset
//   i_REQ_VALID/o_REQ_READY   request handshake (ready only while idle)
//   i_REQ_DATA/MODE/SLAVE/SCK request byte and SPI configuration fields
//   i_REQ_RD                  read RX back after the transfer
//   o_RSP_VALID/DATA/ERR      one-cycle response pulse, RX byte, poll timeout flag
//   o_PSEL..o_PWDATA          APB initiator outputs
//   i_PRDATA, i_PREADY        APB read data and ready
module apb_spi_initiator #(
    parameter logic [15:0] BASE_ADDR = 16'h0040,
    parameter int unsigned XFER_WAIT = 72,
    parameter int unsigned POLL_GAP  = 8,
    parameter int unsigned POLL_MAX  = 16,
    parameter int unsigned BUSY_BIT  = 0
) (
    input  logic        i_PCLK,
    input  logic        i_PRESET,
    input  logic        i_REQ_VALID,
    output logic        o_REQ_READY,
    input  logic [7:0]  i_REQ_DATA,
    input  logic [1:0]  i_REQ_MODE,
    input  logic [1:0]  i_REQ_SLAVE,
    input  logic [1:0]  i_REQ_SCK,
    input  logic        i_REQ_RD,
    output logic        o_RSP_VALID,
    output logic [7:0]  o_RSP_DATA,
    output logic        o_RSP_ERR,
    output logic        o_PSEL,
    output logic        o_PENABLE,
    output logic        o_PWRITE,
    output logic [15:0] o_PADDR,
    output logic [7:0]  o_PWDATA,
    input  logic [7:0]  i_PRDATA,
    input  logic        i_PREADY
);

    typedef enum logic [2:0] {StIdle, StSetup, StAccess, StWait, StGap, StDone} state_e;
    typedef enum logic [2:0] {StepCfg, StepTx, StepCmd, StepSts, StepRx} step_e;

    localparam logic [7:0] WaitLoad = 8'(XFER_WAIT);
    localparam logic [7:0] GapLoad  = 8'(POLL_GAP);
    localparam logic [4:0] PollMax  = 5'(POLL_MAX);
    localparam logic [2:0] BusyIdx  = 3'(BUSY_BIT);

    state_e      state_q, state_d;
    step_e       step_q, step_d;
    logic [7:0]  data_q, data_d;
    logic [5:0]  cfg_q, cfg_d;        // {mode, slave, sck}
    logic        rd_q, rd_d;
    logic [7:0]  cnt_q, cnt_d;        // shared by WAIT and GAP
    logic [4:0]  poll_q, poll_d;
    logic [7:0]  rsp_data_q, rsp_data_d;
    logic        rsp_err_q, rsp_err_d;

    logic [4:0]  poll_inc;
    logic        busy;
    logic [7:0]  addr_off;
    logic [7:0]  wdata;
    logic        is_write;
    logic        in_xfer;

    assign poll_inc = poll_q + 5'd1;
    assign busy     = i_PRDATA[BusyIdx];

    // State register
    always_ff @(posedge i_PCLK or posedge i_PRESET) begin
        if (i_PRESET) begin
            state_q    <= StIdle;
            step_q     <= StepCfg;
            data_q     <= 8'h00;
            cfg_q      <= 6'h00;
            rd_q       <= 1'b0;
            cnt_q      <= 8'h00;
            poll_q     <= 5'h00;
            rsp_data_q <= 8'h00;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            data_q     <= data_d;
            cfg_q      <= cfg_d;
            rd_q       <= rd_d;
            cnt_q      <= cnt_d;
            poll_q     <= poll_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        step_d     = step_q;
        data_d     = data_q;
        cfg_d      = cfg_q;
        rd_d       = rd_q;
        cnt_d      = cnt_q;
        poll_d     = poll_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;

        unique case (state_q)
            StIdle: begin
                if (i_REQ_VALID) begin
                    data_d  = i_REQ_DATA;
                    cfg_d   = {i_REQ_MODE, i_REQ_SLAVE, i_REQ_SCK};
                    rd_d    = i_REQ_RD;
                    poll_d  = 5'h00;
                    step_d  = StepCfg;
                    state_d = StSetup;
                end
            end
            StSetup: state_d = StAccess;
            StAccess: begin
                if (i_PREADY) begin
                    // Every completion leaves at least one bus-idle cycle: a zero WAIT load
                    // gives exactly one.
                    unique case (step_q)
                        StepCfg: begin
                            step_d  = StepTx;
                            cnt_d   = 8'h00;
                            state_d = StWait;
                        end
                        StepTx: begin
                            step_d  = StepCmd;
                            cnt_d   = 8'h00;
                            state_d = StWait;
                        end
                        StepCmd: begin
                            step_d  = StepSts;
                            cnt_d   = WaitLoad;
                            state_d = StWait;
                        end
                        StepSts: begin
                            poll_d = poll_inc;
                            if (busy) begin
                                if (poll_inc >= PollMax) begin
                                    rsp_err_d  = 1'b1;
                                    rsp_data_d = 8'h00;
                                    state_d    = StDone;
                                end else begin
                                    cnt_d   = GapLoad;
                                    state_d = StGap;
                                end
                            end else if (rd_q) begin
                                step_d  = StepRx;
                                cnt_d   = 8'h00;
                                state_d = StWait;
                            end else begin
                                rsp_err_d  = 1'b0;
                                rsp_data_d = 8'h00;
                                state_d    = StDone;
                            end
                        end
                        StepRx: begin
                            rsp_err_d  = 1'b0;
                            rsp_data_d = i_PRDATA;
                            state_d    = StDone;
                        end
                        default: state_d = StIdle;
                    endcase
                end
            end
            // Load N idles for N cycles; loads of 0 and 1 both take a single cycle.
            StWait, StGap: begin
                if (cnt_q <= 8'd1) begin
                    state_d = StSetup;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs
    always_comb begin
        addr_off = 8'h00;
        wdata    = 8'h00;
        is_write = 1'b0;
        unique case (step_q)
            StepCfg: begin addr_off = 8'h00; wdata = {2'b00, cfg_q}; is_write = 1'b1; end
            StepTx:  begin addr_off = 8'h04; wdata = data_q;         is_write = 1'b1; end
            StepCmd: begin addr_off = 8'h0C; wdata = 8'h02;          is_write = 1'b1; end
            StepSts: begin addr_off = 8'h00; end
            StepRx:  begin addr_off = 8'h04; end
            default: ;
        endcase

        in_xfer     = (state_q == StSetup) || (state_q == StAccess);
        o_PSEL      = in_xfer;
        o_PENABLE   = (state_q == StAccess);
        o_PWRITE    = in_xfer && is_write;
        o_PADDR     = in_xfer ? (BASE_ADDR + {8'h00, addr_off}) : 16'h0000;
        o_PWDATA    = (in_xfer && is_write) ? wdata : 8'h00;
        o_REQ_READY = (state_q == StIdle);
        o_RSP_VALID = (state_q == StDone);
        o_RSP_DATA  = rsp_data_q;
        o_RSP_ERR   = rsp_err_q;
    end

endmodule

// File: tb/tb_apb_spi_initiator.sv
// tb_apb_spi_initiator: scoreboard bench for apb_spi_initiator. Expected APB transfers and
// responses are queued when each request is issued; an APB monitor and a response monitor pop
// and compare them as the DUT produces them. A small APB slave model supplies wait states,
// STATUS busy sequences and RX data.
module tb_apb_spi_initiator;

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [7:0]  data;
        int          gap;   // required idle cycles before this transfer, -1 = unchecked
    } apb_t;

    typedef struct {
        logic [7:0] data;
        logic       err;
    } rsp_t;

    logic        clk, rst;
    logic        req_valid, req_ready;
    logic [7:0]  req_data;
    logic [1:0]  req_mode, req_slave, req_sck;
    logic        req_rd;
    logic        rsp_valid;
    logic [7:0]  rsp_data;
    logic        rsp_err;
    logic        psel, penable, pwrite;
    logic [15:0] paddr;
    logic [7:0]  pwdata, prdata;
    logic        pready;

    int checks = 0;
    int errors = 0;

    int         ws_cfg = 0;
    int         busy_left = 0;
    bit         busy_forever = 0;
    logic [7:0] rx_val = 8'h00;

    apb_t apb_q[$];
    rsp_t rsp_q[$];

    apb_spi_initiator #(
        .BASE_ADDR (16'h0040),
        .XFER_WAIT (72),
        .POLL_GAP  (8),
        .POLL_MAX  (16),
        .BUSY_BIT  (0)
    ) dut (
        .i_PCLK      (clk),
        .i_PRESET    (rst),
        .i_REQ_VALID (req_valid),
        .o_REQ_READY (req_ready),
        .i_REQ_DATA  (req_data),
        .i_REQ_MODE  (req_mode),
        .i_REQ_SLAVE (req_slave),
        .i_REQ_SCK   (req_sck),
        .i_REQ_RD    (req_rd),
        .o_RSP_VALID (rsp_valid),
        .o_RSP_DATA  (rsp_data),
        .o_RSP_ERR   (rsp_err),
        .o_PSEL      (psel),
        .o_PENABLE   (penable),
        .o_PWRITE    (pwrite),
        .o_PADDR     (paddr),
        .o_PWDATA    (pwdata),
        .i_PRDATA    (prdata),
        .i_PREADY    (pready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, got, exp);
        end
    endtask

    // APB slave model, driven on the falling edge
    initial begin
        int ws_cnt = 0;
        bit sts_busy;
        pready = 1'b0;
        prdata = 8'h00;
        forever begin
            @(negedge clk);
            if (psel && penable) begin
                if (ws_cnt < ws_cfg) begin
                    pready = 1'b0;
                    ws_cnt++;
                end else begin
                    pready = 1'b1;
                    ws_cnt = 0;
                end
            end else begin
                pready = 1'b0;
                ws_cnt = 0;
            end
            if (psel && !pwrite) begin
                if (paddr == 16'h0040) begin
                    sts_busy = busy_forever || (busy_left > 0);
                    prdata   = sts_busy ? 8'hF1 : 8'hF0;
                    if (pready && busy_left > 0) busy_left--;
                end else if (paddr == 16'h0044) begin
                    prdata = rx_val;
                end else begin
                    prdata = 8'h5A;
                end
            end else begin
                prdata = 8'hEE;
            end
        end
    end

    // APB monitor: protocol rules plus in-order comparison against apb_q
    initial begin
        int          idle_cnt = 0;
        int          gap_seen = 0;
        int          acc_cycles = 0;
        bit          need_idle = 0;
        bit          prev_psel = 0;
        bit          prev_setup = 0;
        logic [15:0] s_addr = '0;
        logic [7:0]  s_data = '0;
        logic        s_wr = 1'b0;
        apb_t        e;
        forever begin
            @(negedge clk);
            #2;
            if (need_idle) begin
                check("idle_after_xfer", 32'(psel), 32'd0);
                need_idle = 0;
            end
            if (!psel) begin
                check("idle_bus_zero", 32'({penable, pwrite, paddr, pwdata}), 32'd0);
                idle_cnt++;
            end else if (!penable) begin
                check("setup_one_cycle", 32'(prev_setup), 32'd0);
                s_addr     = paddr;
                s_data     = pwdata;
                s_wr       = pwrite;
                acc_cycles = 0;
                gap_seen   = idle_cnt;
                idle_cnt   = 0;
            end else begin
                check("access_after_setup", 32'(prev_psel), 32'd1);
                acc_cycles++;
                check("access_stable", 32'({pwrite, paddr, pwdata}),
                      32'({s_wr, s_addr, s_data}));
                if (pready) begin
                    if (apb_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_xfer: got wr %0b addr %0h data %0h required none",
                                 pwrite, paddr, pwdata);
                    end else begin
                        e = apb_q.pop_front();
                        check("xfer_write", 32'(pwrite), 32'(e.wr));
                        check("xfer_addr", 32'(paddr), 32'(e.addr));
                        check("xfer_wdata", 32'(pwdata), 32'(e.data));
                        if (e.gap >= 0) check("idle_gap", gap_seen, e.gap);
                    end
                    check("penable_cycles", acc_cycles, ws_cfg + 1);
                    need_idle = 1;
                end
            end
            prev_psel  = psel;
            prev_setup = psel && !penable;
        end
    end

    // Response monitor
    initial begin
        bit   prev_v = 0;
        rsp_t r;
        forever begin
            @(negedge clk);
            #2;
            if (prev_v) check("ready_after_done", 32'(req_ready), 32'd1);
            if (rsp_valid) begin
                check("ready_low_in_done", 32'(req_ready), 32'd0);
                check("apb_seq_complete", apb_q.size(), 32'd0);
                if (rsp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_response: got data %0h err %0b required none",
                             rsp_data, rsp_err);
                end else begin
                    r = rsp_q.pop_front();
                    check("rsp_data", 32'(rsp_data), 32'(r.data));
                    check("rsp_err", 32'(rsp_err), 32'(r.err));
                end
            end
            prev_v = rsp_valid;
        end
    end

    // Queue the full expected sequence for one request.
    task automatic expect_seq(input logic [7:0] cfg, input logic [7:0] d, input int n_sts,
                              input bit rx_rd, input logic [7:0] rdata, input logic err);
        apb_q.push_back('{1'b1, 16'h0040, cfg, -1});
        apb_q.push_back('{1'b1, 16'h0044, d, -1});
        apb_q.push_back('{1'b1, 16'h004C, 8'h02, -1});
        for (int i = 0; i < n_sts; i++) begin
            apb_q.push_back('{1'b0, 16'h0040, 8'h00, (i == 0) ? 72 : 8});
        end
        if (rx_rd) apb_q.push_back('{1'b0, 16'h0044, 8'h00, -1});
        rsp_q.push_back('{rdata, err});
    endtask

    task automatic send(input logic [7:0] d, input logic [1:0] m, input logic [1:0] s,
                        input logic [1:0] k, input logic rd);
        int n = 0;
        @(negedge clk);
        req_valid = 1'b1;
        req_data  = d;
        req_mode  = m;
        req_slave = s;
        req_sck   = k;
        req_rd    = rd;
        while (!req_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("req_accept", 32'(req_ready), 32'd1);
        @(negedge clk);
        // Scramble the request bus: it must be ignored once accepted.
        req_valid = 1'b0;
        req_data  = ~d;
        req_mode  = ~m;
        req_slave = ~s;
        req_sck   = ~k;
        req_rd    = ~rd;
    endtask

    task automatic wait_rsp();
        int n = 0;
        while (rsp_q.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("rsp_in_time", 32'(rsp_q.size()), 32'd0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int  n;
        bit  found;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_data  = 8'h00;
        req_mode  = 2'b00;
        req_slave = 2'b00;
        req_sck   = 2'b00;
        req_rd    = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_bus", 32'({psel, penable, pwrite, paddr, pwdata}), 32'd0);
        check("rst_rsp", 32'({rsp_valid, rsp_err, rsp_data}), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // T1 write-only
        ws_cfg = 0;
        expect_seq(8'h0D, 8'hA5, 1, 1'b0, 8'h00, 1'b0);
        send(8'hA5, 2'b00, 2'b11, 2'b01, 1'b0);
        wait_rsp();

        // T2 read-back
        rx_val = 8'h3C;
        expect_seq(8'h27, 8'h5E, 1, 1'b1, 8'h3C, 1'b0);
        send(8'h5E, 2'b10, 2'b01, 2'b11, 1'b1);
        wait_rsp();

        // T3 wait states
        ws_cfg = 3;
        expect_seq(8'h0D, 8'hA5, 1, 1'b0, 8'h00, 1'b0);
        send(8'hA5, 2'b00, 2'b11, 2'b01, 1'b0);
        wait_rsp();

        // T4 polling: busy for three reads
        ws_cfg    = 0;
        busy_left = 3;
        rx_val    = 8'h81;
        expect_seq(8'h12, 8'hC3, 4, 1'b1, 8'h81, 1'b0);
        send(8'hC3, 2'b01, 2'b00, 2'b10, 1'b1);
        wait_rsp();

        // T5 timeout with read-back requested
        busy_forever = 1'b1;
        expect_seq(8'h38, 8'h11, 16, 1'b0, 8'h00, 1'b1);
        send(8'h11, 2'b11, 2'b10, 2'b00, 1'b1);
        wait_rsp();
        busy_forever = 1'b0;

        // T6 reset during TX access
        ws_cfg = 3;
        expect_seq(8'h0D, 8'hA5, 1, 1'b0, 8'h00, 1'b0);
        send(8'hA5, 2'b00, 2'b11, 2'b01, 1'b0);
        n     = 0;
        found = 0;
        while (!found && n < 200) begin
            @(negedge clk);
            #3;
            found = psel && penable && (paddr == 16'h0044);
            n++;
        end
        check("found_tx_access", 32'(found), 32'd1);
        rst = 1'b1;
        #1;
        check("rst_async_psel", 32'(psel), 32'd0);
        check("rst_async_penable", 32'(penable), 32'd0);
        apb_q.delete();
        rsp_q.delete();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (100) @(negedge clk);
        check("ready_after_reset", 32'(req_ready), 32'd1);

        ws_cfg = 0;
        expect_seq(8'h0D, 8'hA5, 1, 1'b0, 8'h00, 1'b0);
        send(8'hA5, 2'b00, 2'b11, 2'b01, 1'b0);
        wait_rsp();

        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
